// File: rtl/rv32m_muldiv_unit.sv
// rtl/rv32m_muldiv_unit.sv - iterative RV32M multiply/divide unit with pipeline stall request
module rv32m_muldiv_unit #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  flush,
  output logic [data_width-1:0] ALU_result,
  output logic                  done,
  output logic                  busy,
  output logic                  hold_pipeline
);

  localparam int W  = data_width;
  localparam int CW = $clog2(data_width);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_result;

  logic             w_load, w_fast, w_last;
  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [W-1:0]     w_a_abs, w_b_abs;
  logic             w_div_zero, w_ovf, w_special;
  logic [W-1:0]     w_fast_result;
  logic [W:0]       w_sum, w_rem_sh;
  logic [W-1:0]     w_rem_sub;
  logic             w_ge;
  logic [2*W-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod_fix;
  logic [W-1:0]     w_quot_fix, w_rem_fix, w_final;

  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_a_neg    = w_a_signed && operand_A[W-1];
  assign w_b_neg    = w_b_signed && operand_B[W-1];
  assign w_a_abs    = w_a_neg ? -operand_A : operand_A;
  assign w_b_abs    = w_b_neg ? -operand_B : operand_B;
  // REM takes the dividend sign; every other signed op negates on differing signs
  assign w_neg      = (op == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = op[2] && (operand_B == '0);
  assign w_ovf      = ((op == 3'b100) || (op == 3'b110)) &&
                      (operand_A == {1'b1, {(W-1){1'b0}}}) && (operand_B == '1);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero)
      w_fast_result = op[1] ? operand_A : '1;
    else
      w_fast_result = op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // Shift-add step: add multiplicand into the upper half, keep the carry through the shift
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};

  // Restoring step: shifted remainder needs W+1 bits before the compare
  assign w_rem_sh  = r_acc[2*W-1:W-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[W-1:0] - r_b;
  assign w_div_nxt = {(w_ge ? w_rem_sub : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

  assign w_acc_nxt  = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quot_fix = r_neg ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];
  assign w_rem_fix  = r_neg ? -w_acc_nxt[2*W-1:W] : w_acc_nxt[2*W-1:W];

  always_comb begin
    case (r_op)
      3'b000:                  w_final = w_prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011:  w_final = w_prod_fix[2*W-1:W];
      3'b100, 3'b101:          w_final = w_quot_fix;
      default:                 w_final = w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_fast        = 1'b0;
    w_last        = (r_cnt == CW'(W-1));
    done          = 1'b0;
    busy          = 1'b0;
    hold_pipeline = 1'b0;
    case (r_state)
      S_IDLE: begin
        hold_pipeline = start;
        if (start && !flush) begin
          if (w_special) begin
            w_state_nxt = S_DONE;
            w_fast      = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
            w_load      = 1'b1;
          end
        end
      end
      S_CALC: begin
        busy          = 1'b1;
        hold_pipeline = 1'b1;
        if (flush)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_op  <= op;
        r_neg <= w_neg;
        r_cnt <= '0;
        if (op[2]) begin
          r_b   <= w_b_abs;
          r_acc <= {{W{1'b0}}, w_a_abs};
        end else begin
          r_b   <= w_a_abs;
          r_acc <= {{W{1'b0}}, w_b_abs};
        end
      end else if ((r_state == S_CALC) && !flush) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_result <= w_final;
      end
      if (w_fast) r_result <= w_fast_result;
    end
  end

  assign ALU_result = r_result;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb/tb_rv32m_muldiv_unit.sv - self-checking bench for rv32m_muldiv_unit
module tb_rv32m_muldiv_unit;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic [31:0] ALU_result;
  logic        done, busy, hold_pipeline;

  int checks = 0;
  int errors = 0;

  rv32m_muldiv_unit #(.data_width(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_A(A), .operand_B(B), .flush(flush),
    .ALU_result(ALU_result), .done(done), .busy(busy),
    .hold_pipeline(hold_pipeline)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      3'd0: begin up = ua * ub; r = up[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else begin sp = sa / sb; r = sp[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else begin sp = sa % sb; r = sp[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Behavioural model: phase 0 idle, 1 computing, 2 result cycle
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
    end else begin
      case (m_phase)
        0: if (start && !flush) begin
          if (is_fast(op, A, B)) begin
            m_res   <= ref_res(op, A, B);
            m_phase <= 2;
          end else begin
            m_pend  <= ref_res(op, A, B);
            m_left  <= 32;
            m_phase <= 1;
          end
        end
        1: if (flush) m_phase <= 0;
           else begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_phase <= 2;
               m_res   <= m_pend;
             end
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("done",   {31'b0, done},          {31'b0, m_phase == 2});
    chk("busy",   {31'b0, busy},          {31'b0, m_phase != 0});
    chk("hold",   {31'b0, hold_pipeline}, {31'b0, (m_phase == 0 && start) || m_phase == 1});
    chk("result", ALU_result,             m_res);
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int n;
    bit seen;
    @(negedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      if (n == 1) begin #1; start = 1'b0; end
    end
    chk({name, "_seen"}, {31'b0, seen}, 32'd1);
    chk({name, "_lat"},  n,             lat);
    chk({name, "_val"},  ALU_result,    exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;

    chk("pin_mul",    ref_res(3'd0, 32'd10, 32'd5), 32'h00000032);
    chk("pin_mulh",   ref_res(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("pin_mulhu",  ref_res(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("pin_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("pin_div",    ref_res(3'd4, -32'sd7, 32'd2), 32'hFFFFFFFD);
    chk("pin_rem",    ref_res(3'd6, -32'sd7, 32'd2), 32'hFFFFFFFF);
    chk("pin_divu",   ref_res(3'd5, 32'd100, 32'd7), 32'd14);
    chk("pin_remu",   ref_res(3'd7, 32'd100, 32'd7), 32'd2);
    chk("pin_divz",   ref_res(3'd5, 32'd7, 32'd0), 32'hFFFFFFFF);
    chk("pin_ovf",    ref_res(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

    repeat (2) @(negedge clk);
    chk("rst_result", ALU_result, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    #1 rst = 1'b0;

    do_op(3'd0, 32'd10, 32'd5, 32'h00000032, 33, "mul");
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, "mulhsu");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    do_op(3'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 1, "divu0");
    do_op(3'd7, 32'd7, 32'd0, 32'd7, 1, "remu0");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");

    // flush mid-divide, then a fresh multiply two cycles later
    @(negedge clk); #1; start = 1'b1; op = 3'd4; A = 32'd50; B = 32'd5;
    @(negedge clk); #1; start = 1'b0;
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    chk("flush_busy",   {31'b0, busy}, 32'h0);
    chk("flush_keep",   ALU_result,    32'h0);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");

    // reset in cycle 15 of a divide
    @(negedge clk); #1; start = 1'b1; op = 3'd4; A = 32'd50; B = 32'd5;
    @(negedge clk); #1; start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_result", ALU_result, 32'h0);
    chk("midrst_busy",   {31'b0, busy}, 32'h0);
    chk("midrst_done",   {31'b0, done}, 32'h0);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);

    // second start during CALC is ignored
    #1; start = 1'b1; op = 3'd0; A = 32'd10; B = 32'd5;
    @(negedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    #1; start = 1'b1; op = 3'd5; A = 32'd100; B = 32'd7;
    @(negedge clk); #1; start = 1'b0;
    n = 6;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("restart_lat", n, 33);
    chk("restart_val", ALU_result, 32'd50);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 799) == 0);
      op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
    end
    @(negedge clk); #1;
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
Multi-cycle responder for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that the ALU dispatches and cannot complete in one cycle. Sits beside the ALU in EX, accepts one operation per start pulse, and drives hold_pipeline to stall the pipe until the result is ready. Uses an iterative radix-2 shift-add multiplier and a restoring divider sharing one 64-bit datapath.

Parameters:
data_width, 32, operand/result width; the iteration count equals data_width.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_A  input  data_width  rs1 value (dividend / multiplicand)
operand_B  input  data_width  rs2 value (divisor / multiplier)
flush  input  1  abort the in-flight operation (branch mispredict / exception)
ALU_result  output  data_width  registered result; holds until next accepted start
done  output  1  one-cycle pulse: ALU_result valid
busy  output  1  high in CALC and DONE states
hold_pipeline  output  1  combinational stall request to hazard unit

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. On rst: state IDLE, ALU_result=0, done=0, busy=0, counter=0, internal registers=0. rst overrides start and flush in the same cycle. rst mid-operation discards that operation; no done follows.
- States:
  - IDLE: wait for start.
  - CALC: iterate.
  - DONE: present result for one cycle, then return to IDLE.
- IDLE to CALC: start=1 and no special case. Latch op. Latch |A| and |B| per signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - Unsigned ops: no sign handling.
  - Latch the result-negate flag and the remainder sign.
- IDLE to DONE (fast path, done in the cycle after start):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_A.
  - Signed overflow, A=0x80000000 and B=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC: counter 0..data_width-1, one iteration per cycle.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper product half; then shift right 1.
  - Divide: shift {rem,quot} left 1; if rem >= divisor, subtract and set quot LSB.
  - After iteration data_width-1, go to DONE.
  - On entering DONE, apply sign correction (two's complement):
    - MUL returns low 32 bits of the 64-bit product.
    - MULH/MULHSU/MULHU return high 32 bits.
    - Quotient is negated if signs differ; remainder takes the sign of the dividend.
- Latency: start sampled at edge 0 gives CALC cycles 1..32 and done=1 in cycle 33 (33 cycles). Fast path: done=1 in cycle 1.
- hold_pipeline = (state==IDLE & start) | (state==CALC). It is low in DONE, so the pipeline advances and captures ALU_result in the done cycle.
- start while not IDLE is ignored; operands are not re-latched. Back-to-back: a start in the DONE cycle is ignored; the next start is accepted in the following IDLE cycle.
- flush in CALC or DONE: go to IDLE next edge. done is forced 0 from that edge. ALU_result keeps its previous value. flush in IDLE with start: the start is dropped.
- Width rules: internal product/remainder registers are 2*data_width. Negation of 0x80000000 wraps to 0x80000000, which is a legal intermediate.

Test Plan:
- MUL 10*5: start at edge 0 -> hold_pipeline=1 for cycles 0..32; done=1 in cycle 33 with ALU_result=50 (0x00000032); busy=0 in cycle 34.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF(-1)*0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done in cycle 33.
- DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7, each with done in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, fast path.
- DIV 50/5 started; flush=1 in cycle 10 -> IDLE at cycle 11; no done ever; ALU_result unchanged. A new start MUL 3*4 in cycle 12 -> done in cycle 45 with result 12.
- rst=1 in cycle 15 of a DIV -> all outputs 0 at the next edge, no done. A second start during CALC (different operands) is ignored and the original result is returned.
